// File: rtl/instr_sequencer_pkg.sv
// rtl/instr_sequencer_pkg.sv - shared ALU op codes, opcode fields, Q-phase and instruction-class types
package instr_sequencer_pkg;

  // ALU operation codes understood by the shared ALU
  localparam logic [3:0] ALU_ADD    = 4'h0;
  localparam logic [3:0] ALU_AND    = 4'h1;
  localparam logic [3:0] ALU_CLR    = 4'h2;
  localparam logic [3:0] ALU_COM    = 4'h3;
  localparam logic [3:0] ALU_DEC    = 4'h4;
  localparam logic [3:0] ALU_INC    = 4'h5;
  localparam logic [3:0] ALU_OR     = 4'h6;
  localparam logic [3:0] ALU_PASSLF = 4'h7;
  localparam logic [3:0] ALU_PASSW  = 4'h8;
  localparam logic [3:0] ALU_RLF    = 4'h9;
  localparam logic [3:0] ALU_RRF    = 4'hA;
  localparam logic [3:0] ALU_SUB    = 4'hB;
  localparam logic [3:0] ALU_SWAPF  = 4'hC;
  localparam logic [3:0] ALU_XOR    = 4'hD;

  // Whole-word encodings
  localparam logic [13:0] INSTR_NOP = 14'h0000;
  localparam logic [13:0] OP_RETURN = 14'h0008;
  localparam logic [13:0] OP_RETFIE = 14'h0009;

  // Opcode group, ir[13:12]
  localparam logic [1:0] GRP_BYTE = 2'b00;
  localparam logic [1:0] GRP_BIT  = 2'b01;
  localparam logic [1:0] GRP_CTRL = 2'b10;
  localparam logic [1:0] GRP_LIT  = 2'b11;

  // Byte-oriented op field, ir[11:8]
  localparam logic [3:0] BOP_MISC   = 4'h0;
  localparam logic [3:0] BOP_CLR    = 4'h1;
  localparam logic [3:0] BOP_SUBWF  = 4'h2;
  localparam logic [3:0] BOP_DECF   = 4'h3;
  localparam logic [3:0] BOP_IORWF  = 4'h4;
  localparam logic [3:0] BOP_ANDWF  = 4'h5;
  localparam logic [3:0] BOP_XORWF  = 4'h6;
  localparam logic [3:0] BOP_ADDWF  = 4'h7;
  localparam logic [3:0] BOP_MOVF   = 4'h8;
  localparam logic [3:0] BOP_COMF   = 4'h9;
  localparam logic [3:0] BOP_INCF   = 4'hA;
  localparam logic [3:0] BOP_DECFSZ = 4'hB;
  localparam logic [3:0] BOP_RRF    = 4'hC;
  localparam logic [3:0] BOP_RLF    = 4'hD;
  localparam logic [3:0] BOP_SWAPF  = 4'hE;
  localparam logic [3:0] BOP_INCFSZ = 4'hF;

  // Bit-oriented op field, ir[11:10]
  localparam logic [1:0] BIT_BCF   = 2'b00;
  localparam logic [1:0] BIT_BSF   = 2'b01;
  localparam logic [1:0] BIT_BTFSC = 2'b10;
  localparam logic [1:0] BIT_BTFSS = 2'b11;

  // Literal op fields (matched on ir[11:10], ir[11:9] or ir[11:8])
  localparam logic [1:0] LOP_MOVLW = 2'b00;
  localparam logic [1:0] LOP_RETLW = 2'b01;
  localparam logic [2:0] LOP_SUBLW = 3'b110;
  localparam logic [2:0] LOP_ADDLW = 3'b111;
  localparam logic [3:0] LOP_IORLW = 4'h8;
  localparam logic [3:0] LOP_ANDLW = 4'h9;
  localparam logic [3:0] LOP_XORLW = 4'hA;

  typedef enum logic [1:0] {Q1 = 2'd0, Q2 = 2'd1, Q3 = 2'd2, Q4 = 2'd3} q_phase_e;

  typedef enum logic [3:0] {
    CLS_NOP    = 4'd0,
    CLS_BYTE   = 4'd1,
    CLS_BIT    = 4'd2,
    CLS_LIT    = 4'd3,
    CLS_GOTO   = 4'd4,
    CLS_CALL   = 4'd5,
    CLS_RETURN = 4'd6,
    CLS_RETLW  = 4'd7,
    CLS_RETFIE = 4'd8
  } instr_class_e;

  typedef enum logic [1:0] {SKIP_NONE = 2'd0, SKIP_Z = 2'd1, SKIP_BCLR = 2'd2, SKIP_BSET = 2'd3} skip_e;

  typedef enum logic [1:0] {WB_NONE = 2'd0, WB_F = 2'd1, WB_W = 2'd2} wb_e;

endpackage

// File: rtl/instr_sequencer_decoder.sv
// rtl/instr_sequencer_decoder.sv - combinational 14-bit mid-range opcode decoder
module instr_decoder
  import instr_sequencer_pkg::*;
(
  input  logic [13:0] ir,
  output logic [3:0]  cls,
  output logic [3:0]  alu_op,
  output logic        alu_sel_lit,
  output logic        rd_f,
  output logic [1:0]  wb,
  output logic        status_en,
  output logic [1:0]  skip,
  output logic        bit_set,
  output logic        bit_clr
);

  logic [1:0] dest_d;

  // d-bit selects the byte-op writeback target
  assign dest_d = ir[7] ? WB_F : WB_W;

  // Decode everything to NOP first; each recognised encoding overrides what it needs
  always_comb begin
    cls         = CLS_NOP;
    alu_op      = ALU_ADD;
    alu_sel_lit = 1'b0;
    rd_f        = 1'b0;
    wb          = WB_NONE;
    status_en   = 1'b0;
    skip        = SKIP_NONE;
    bit_set     = 1'b0;
    bit_clr     = 1'b0;
    case (ir[13:12])
      GRP_BYTE: begin
        if (ir[11:8] == BOP_MISC) begin
          if (ir[7]) begin
            cls    = CLS_BYTE;
            alu_op = ALU_PASSW;
            wb     = WB_F;
          end else if (ir == OP_RETURN) begin
            cls = CLS_RETURN;
          end else if (ir == OP_RETFIE) begin
            cls = CLS_RETFIE;
          end
        end else if (ir[11:8] == BOP_CLR) begin
          cls       = CLS_BYTE;
          alu_op    = ALU_CLR;
          wb        = dest_d;
          status_en = 1'b1;
        end else begin
          cls       = CLS_BYTE;
          rd_f      = 1'b1;
          wb        = dest_d;
          status_en = 1'b1;
          case (ir[11:8])
            BOP_SUBWF:  alu_op = ALU_SUB;
            BOP_DECF:   alu_op = ALU_DEC;
            BOP_IORWF:  alu_op = ALU_OR;
            BOP_ANDWF:  alu_op = ALU_AND;
            BOP_XORWF:  alu_op = ALU_XOR;
            BOP_ADDWF:  alu_op = ALU_ADD;
            BOP_MOVF:   alu_op = ALU_PASSLF;
            BOP_COMF:   alu_op = ALU_COM;
            BOP_INCF:   alu_op = ALU_INC;
            BOP_DECFSZ: begin alu_op = ALU_DEC;   status_en = 1'b0; skip = SKIP_Z; end
            BOP_RRF:    alu_op = ALU_RRF;
            BOP_RLF:    alu_op = ALU_RLF;
            BOP_SWAPF:  begin alu_op = ALU_SWAPF; status_en = 1'b0; end
            BOP_INCFSZ: begin alu_op = ALU_INC;   status_en = 1'b0; skip = SKIP_Z; end
            default:    alu_op = ALU_ADD;
          endcase
        end
      end
      GRP_BIT: begin
        cls    = CLS_BIT;
        alu_op = ALU_PASSLF;
        rd_f   = 1'b1;
        case (ir[11:10])
          BIT_BCF:   begin wb = WB_F; bit_clr = 1'b1; end
          BIT_BSF:   begin wb = WB_F; bit_set = 1'b1; end
          BIT_BTFSC: skip = SKIP_BCLR;
          default:   skip = SKIP_BSET;
        endcase
      end
      GRP_CTRL: begin
        cls = ir[11] ? CLS_GOTO : CLS_CALL;
      end
      default: begin
        if (ir[11:10] == LOP_MOVLW) begin
          cls = CLS_LIT; alu_op = ALU_PASSLF; alu_sel_lit = 1'b1; wb = WB_W;
        end else if (ir[11:10] == LOP_RETLW) begin
          cls = CLS_RETLW; alu_op = ALU_PASSLF; alu_sel_lit = 1'b1; wb = WB_W;
        end else if (ir[11:9] == LOP_SUBLW) begin
          cls = CLS_LIT; alu_op = ALU_SUB; alu_sel_lit = 1'b1; wb = WB_W; status_en = 1'b1;
        end else if (ir[11:9] == LOP_ADDLW) begin
          cls = CLS_LIT; alu_op = ALU_ADD; alu_sel_lit = 1'b1; wb = WB_W; status_en = 1'b1;
        end else if (ir[11:8] == LOP_IORLW) begin
          cls = CLS_LIT; alu_op = ALU_OR; alu_sel_lit = 1'b1; wb = WB_W; status_en = 1'b1;
        end else if (ir[11:8] == LOP_ANDLW) begin
          cls = CLS_LIT; alu_op = ALU_AND; alu_sel_lit = 1'b1; wb = WB_W; status_en = 1'b1;
        end else if (ir[11:8] == LOP_XORLW) begin
          cls = CLS_LIT; alu_op = ALU_XOR; alu_sel_lit = 1'b1; wb = WB_W; status_en = 1'b1;
        end
      end
    endcase
  end

endmodule

// File: rtl/instr_sequencer.sv
// rtl/instr_sequencer.sv - Q1..Q4 instruction-cycle sequencer with IR, flush flag and strobe gating
module instr_sequencer
  import instr_sequencer_pkg::*;
#(
  parameter int PC_WIDTH      = 13,
  parameter int RF_ADDR_WIDTH = 7
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic [13:0]              instr_in,
  input  logic                     alu_z,
  input  logic                     alu_bit_test_res,
  output logic [1:0]               q_phase,
  output logic [13:0]              ir,
  output logic [3:0]               alu_op,
  output logic                     alu_sel_lit,
  output logic [7:0]               literal,
  output logic                     alu_status_wr_en,
  output logic [RF_ADDR_WIDTH-1:0] rf_addr,
  output logic                     rf_rd_en,
  output logic                     rf_wr_en,
  output logic                     w_wr_en,
  output logic [2:0]               bit_sel,
  output logic                     bit_set_en,
  output logic                     bit_clr_en,
  output logic                     pc_inc,
  output logic                     pc_load,
  output logic [10:0]              pc_load_addr,
  output logic                     stack_push,
  output logic                     stack_pop,
  output logic                     gie_set,
  output logic                     flushing
);

  // Branch target is clipped to the PC width when the PC is narrower than the field
  localparam int TGT_W = (PC_WIDTH < 11) ? PC_WIDTH : 11;

  q_phase_e    q_r;
  q_phase_e    q_next;
  logic [13:0] ir_r;
  logic        flush_r;
  logic [13:0] dec_ir;
  logic        active;

  logic [3:0]  d_cls;
  logic [3:0]  d_alu_op;
  logic        d_sel_lit;
  logic        d_rd_f;
  logic [1:0]  d_wb;
  logic        d_status;
  logic [1:0]  d_skip;
  logic        d_bit_set;
  logic        d_bit_clr;

  logic        is_load;
  logic        is_push;
  logic        is_pop;
  logic        is_gie;
  logic        skip_taken;
  logic        redirect;

  // Reset in flight also blocks strobes so no partial Q4 escapes
  assign active = en && !rst;
  // A flushed cycle executes the fetched word as a NOP
  assign dec_ir = flush_r ? INSTR_NOP : ir_r;

  // Q-phase state register; en=0 freezes the phase
  always_ff @(posedge clk) begin
    if (rst) begin
      q_r <= Q1;
    end else if (en) begin
      q_r <= q_next;
    end
  end

  // Q-phase advance Q1 -> Q2 -> Q3 -> Q4 -> Q1
  always_comb begin
    q_next = q_r;
    case (q_r)
      Q1: q_next = Q2;
      Q2: q_next = Q3;
      Q3: q_next = Q4;
      Q4: q_next = Q1;
    endcase
  end

  // IR fetch and flush decision happen together at the end of Q4
  always_ff @(posedge clk) begin
    if (rst) begin
      ir_r    <= INSTR_NOP;
      flush_r <= 1'b0;
    end else if (en && q_r == Q4) begin
      ir_r    <= instr_in;
      flush_r <= redirect;
    end
  end

  instr_decoder u_decoder (
    .ir          (dec_ir),
    .cls         (d_cls),
    .alu_op      (d_alu_op),
    .alu_sel_lit (d_sel_lit),
    .rd_f        (d_rd_f),
    .wb          (d_wb),
    .status_en   (d_status),
    .skip        (d_skip),
    .bit_set     (d_bit_set),
    .bit_clr     (d_bit_clr)
  );

  assign is_load = (d_cls == CLS_GOTO) || (d_cls == CLS_CALL);
  assign is_push = (d_cls == CLS_CALL);
  assign is_pop  = (d_cls == CLS_RETURN) || (d_cls == CLS_RETLW) || (d_cls == CLS_RETFIE);
  assign is_gie  = (d_cls == CLS_RETFIE);

  assign skip_taken = ((d_skip == SKIP_Z)    &&  alu_z) ||
                      ((d_skip == SKIP_BCLR) && !alu_bit_test_res) ||
                      ((d_skip == SKIP_BSET) &&  alu_bit_test_res);
  // Anything that changes the fetch stream discards the word already fetched
  assign redirect = skip_taken || is_load || is_pop;

  // Phase-qualified strobes: read in Q2, writeback and PC/stack control in Q4
  always_comb begin
    rf_rd_en         = 1'b0;
    rf_wr_en         = 1'b0;
    w_wr_en          = 1'b0;
    alu_status_wr_en = 1'b0;
    bit_set_en       = 1'b0;
    bit_clr_en       = 1'b0;
    pc_inc           = 1'b0;
    pc_load          = 1'b0;
    stack_push       = 1'b0;
    stack_pop        = 1'b0;
    gie_set          = 1'b0;
    if (active && q_r == Q2) begin
      rf_rd_en = d_rd_f;
    end
    if (active && q_r == Q4) begin
      rf_wr_en         = (d_wb == WB_F);
      w_wr_en          = (d_wb == WB_W);
      alu_status_wr_en = d_status;
      bit_set_en       = d_bit_set;
      bit_clr_en       = d_bit_clr;
      pc_load          = is_load;
      stack_push       = is_push;
      stack_pop        = is_pop;
      gie_set          = is_gie;
      pc_inc           = !(is_load || is_pop);
    end
  end

  assign q_phase      = q_r;
  assign ir           = ir_r;
  assign alu_op       = d_alu_op;
  assign alu_sel_lit  = d_sel_lit;
  assign literal      = ir_r[7:0];
  assign rf_addr      = ir_r[RF_ADDR_WIDTH-1:0];
  assign bit_sel      = ir_r[9:7];
  assign pc_load_addr = 11'(ir_r[TGT_W-1:0]);
  assign flushing     = flush_r;

endmodule

// File: tb/tb_instr_sequencer.sv
// tb/tb_instr_sequencer.sv - scoreboard bench for instr_sequencer with an instruction-level reference model
module tb_instr_sequencer;
  import instr_sequencer_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [13:0] instr_in;
  logic        alu_z;
  logic        alu_bit_test_res;
  logic [1:0]  q_phase;
  logic [13:0] ir;
  logic [3:0]  alu_op;
  logic        alu_sel_lit;
  logic [7:0]  literal;
  logic        alu_status_wr_en;
  logic [6:0]  rf_addr;
  logic        rf_rd_en;
  logic        rf_wr_en;
  logic        w_wr_en;
  logic [2:0]  bit_sel;
  logic        bit_set_en;
  logic        bit_clr_en;
  logic        pc_inc;
  logic        pc_load;
  logic [10:0] pc_load_addr;
  logic        stack_push;
  logic        stack_pop;
  logic        gie_set;
  logic        flushing;

  instr_sequencer dut (
    .clk              (clk),
    .rst              (rst),
    .en               (en),
    .instr_in         (instr_in),
    .alu_z            (alu_z),
    .alu_bit_test_res (alu_bit_test_res),
    .q_phase          (q_phase),
    .ir               (ir),
    .alu_op           (alu_op),
    .alu_sel_lit      (alu_sel_lit),
    .literal          (literal),
    .alu_status_wr_en (alu_status_wr_en),
    .rf_addr          (rf_addr),
    .rf_rd_en         (rf_rd_en),
    .rf_wr_en         (rf_wr_en),
    .w_wr_en          (w_wr_en),
    .bit_sel          (bit_sel),
    .bit_set_en       (bit_set_en),
    .bit_clr_en       (bit_clr_en),
    .pc_inc           (pc_inc),
    .pc_load          (pc_load),
    .pc_load_addr     (pc_load_addr),
    .stack_push       (stack_push),
    .stack_pop        (stack_pop),
    .gie_set          (gie_set),
    .flushing         (flushing)
  );

  always #5 clk = ~clk;

  // {rf_rd, rf_wr, w_wr, status, bit_set, bit_clr, pc_inc, pc_load, push, pop, gie}
  logic [10:0] all_strobes;
  assign all_strobes = {rf_rd_en, rf_wr_en, w_wr_en, alu_status_wr_en, bit_set_en, bit_clr_en,
                        pc_inc, pc_load, stack_push, stack_pop, gie_set};

  typedef struct packed {
    logic [13:0] ir;
    logic        rd;
    logic        fl;
  } q2_exp_t;

  typedef struct packed {
    logic [13:0] ir;
    logic [3:0]  op;
    logic        lit;
    logic [9:0]  stb;
    logic        fl;
  } q4_exp_t;

  q2_exp_t q2_q[$];
  q4_exp_t q4_q[$];
  q2_exp_t e2;
  q4_exp_t e4;

  int   checks = 0;
  int   errors = 0;
  logic mon_on = 1'b0;

  logic [13:0] cur_ir;
  logic        cur_flush;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic string mnem(input logic [13:0] i);
    casez (i)
      14'b00_0000_0000_1000: return "RETURN";
      14'b00_0000_0000_1001: return "RETFIE";
      14'b00_0000_1???_????: return "MOVWF";
      14'b00_0001_0???_????: return "CLRW";
      14'b00_0001_1???_????: return "CLRF";
      14'b00_0010_????_????: return "SUBWF";
      14'b00_0011_????_????: return "DECF";
      14'b00_0100_????_????: return "IORWF";
      14'b00_0101_????_????: return "ANDWF";
      14'b00_0110_????_????: return "XORWF";
      14'b00_0111_????_????: return "ADDWF";
      14'b00_1000_????_????: return "MOVF";
      14'b00_1001_????_????: return "COMF";
      14'b00_1010_????_????: return "INCF";
      14'b00_1011_????_????: return "DECFSZ";
      14'b00_1100_????_????: return "RRF";
      14'b00_1101_????_????: return "RLF";
      14'b00_1110_????_????: return "SWAPF";
      14'b00_1111_????_????: return "INCFSZ";
      14'b01_00??_????_????: return "BCF";
      14'b01_01??_????_????: return "BSF";
      14'b01_10??_????_????: return "BTFSC";
      14'b01_11??_????_????: return "BTFSS";
      14'b10_0???_????_????: return "CALL";
      14'b10_1???_????_????: return "GOTO";
      14'b11_00??_????_????: return "MOVLW";
      14'b11_01??_????_????: return "RETLW";
      14'b11_1000_????_????: return "IORLW";
      14'b11_1001_????_????: return "ANDLW";
      14'b11_1010_????_????: return "XORLW";
      14'b11_110?_????_????: return "SUBLW";
      14'b11_111?_????_????: return "ADDLW";
      default:               return "NOP";
    endcase
  endfunction

  // Instruction-level behaviour of one whole instruction cycle
  function automatic void model(input logic [13:0] i, input logic fl, input logic z, input logic bt,
                                output logic rd, output logic [9:0] stb, output logic [3:0] op,
                                output logic lit, output logic fnext);
    string m;
    logic rfw, ww, st, bs, bc, ld, pu, po, gi, sk;
    m = fl ? "NOP" : mnem(i);
    rd = 0; rfw = 0; ww = 0; st = 0; bs = 0; bc = 0; ld = 0; pu = 0; po = 0; gi = 0; sk = 0;
    op = 4'h0; lit = 0;
    case (m)
      "ADDWF", "ADDLW":            op = ALU_ADD;
      "ANDWF", "ANDLW":            op = ALU_AND;
      "CLRF", "CLRW":              op = ALU_CLR;
      "COMF":                      op = ALU_COM;
      "DECF", "DECFSZ":            op = ALU_DEC;
      "INCF", "INCFSZ":            op = ALU_INC;
      "IORWF", "IORLW":            op = ALU_OR;
      "MOVF", "MOVLW", "RETLW", "BCF", "BSF", "BTFSC", "BTFSS": op = ALU_PASSLF;
      "MOVWF":                     op = ALU_PASSW;
      "RLF":                       op = ALU_RLF;
      "RRF":                       op = ALU_RRF;
      "SUBWF", "SUBLW":            op = ALU_SUB;
      "SWAPF":                     op = ALU_SWAPF;
      "XORWF", "XORLW":            op = ALU_XOR;
      default:                     op = 4'h0;
    endcase
    case (m)
      "ADDWF", "ANDWF", "COMF", "DECF", "DECFSZ", "INCF", "INCFSZ", "IORWF", "MOVF",
      "RLF", "RRF", "SUBWF", "SWAPF", "XORWF": begin
        rd = 1;
        if (i[7]) rfw = 1; else ww = 1;
      end
      "MOVWF":                                  rfw = 1;
      "CLRF", "CLRW":                           if (i[7]) rfw = 1; else ww = 1;
      "MOVLW", "RETLW", "ADDLW", "ANDLW", "IORLW", "SUBLW", "XORLW": begin
        ww = 1; lit = 1;
      end
      "BCF":             begin rd = 1; rfw = 1; bc = 1; end
      "BSF":             begin rd = 1; rfw = 1; bs = 1; end
      "BTFSC", "BTFSS":  rd = 1;
      default:           rd = 0;
    endcase
    case (m)
      "ADDWF", "ANDWF", "CLRF", "CLRW", "COMF", "DECF", "INCF", "IORWF", "MOVF", "RLF",
      "RRF", "SUBWF", "XORWF", "ADDLW", "ANDLW", "IORLW", "SUBLW", "XORLW": st = 1;
      default: st = 0;
    endcase
    case (m)
      "DECFSZ", "INCFSZ": sk = z;
      "BTFSC":            sk = !bt;
      "BTFSS":            sk = bt;
      "GOTO":             ld = 1;
      "CALL":             begin ld = 1; pu = 1; end
      "RETURN", "RETLW":  po = 1;
      "RETFIE":           begin po = 1; gi = 1; end
      default:            sk = 0;
    endcase
    stb   = {rfw, ww, st, bs, bc, !(ld || po), ld, pu, po, gi};
    fnext = sk || ld || po;
  endfunction

  // One instruction cycle: predict what executes now, present the next word, clock four phases
  task automatic run_cycle(input logic [13:0] next_instr, input logic z, input logic bt, input int stall_pct);
    logic rd, lit, fnext;
    logic [9:0] stb;
    logic [3:0] op;
    model(cur_ir, cur_flush, z, bt, rd, stb, op, lit, fnext);
    q2_q.push_back('{ir: cur_ir, rd: rd, fl: cur_flush});
    q4_q.push_back('{ir: cur_ir, op: op, lit: lit, stb: stb, fl: cur_flush});
    cur_ir    = next_instr;
    cur_flush = fnext;
    instr_in         = next_instr;
    alu_z            = z;
    alu_bit_test_res = bt;
    for (int p = 0; p < 4; p++) begin
      int n;
      n = 0;
      while (n < 3 && $urandom_range(0, 99) < stall_pct) begin
        en = 1'b0;
        @(posedge clk); #1;
        n++;
      end
      en = 1'b1;
      @(posedge clk); #1;
    end
  endtask

  function automatic logic [13:0] rand_instr();
    logic [13:0] r;
    r = 14'($urandom);
    case ($urandom_range(0, 11))
      0:         return 14'h0008;
      1:         return 14'h0009;
      2:         return r & 14'h0060;
      3:         return r[0] ? 14'h0063 : 14'h0064;
      4:         return r & 14'h01FF;
      5, 6, 7:   return {2'b00, 4'($urandom_range(2, 15)), r[7:0]};
      8:         return {2'b01, r[11:0]};
      9:         return {2'b10, r[11:0]};
      10:        return {2'b11, r[11:0]};
      default:   return r;
    endcase
  endfunction

  // Monitor: compare against the queued expectation whenever the DUT is at an active phase
  always @(negedge clk) begin
    if (mon_on && !rst) begin
      if (!en) begin
        check("stalled_strobes", all_strobes, 0);
      end else if (q_phase == 2'd1) begin
        if (q2_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL q2_underflow: got empty queue expected an entry (t=%0t)", $time);
        end else begin
          e2 = q2_q.pop_front();
          check("q2_strobes", all_strobes, {e2.rd, 10'b0});
          check("q2_rf_addr", rf_addr, e2.ir[6:0]);
          check("q2_flushing", flushing, e2.fl);
        end
      end else if (q_phase == 2'd3) begin
        if (q4_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL q4_underflow: got empty queue expected an entry (t=%0t)", $time);
        end else begin
          e4 = q4_q.pop_front();
          check("q4_strobes", all_strobes, {1'b0, e4.stb});
          check("q4_alu_op", alu_op, e4.op);
          check("q4_alu_sel_lit", alu_sel_lit, e4.lit);
          check("q4_flushing", flushing, e4.fl);
          check("q4_ir", ir, e4.ir);
          check("q4_literal", literal, e4.ir[7:0]);
          check("q4_bit_sel", bit_sel, e4.ir[9:7]);
          check("q4_pc_load_addr", pc_load_addr, e4.ir[10:0]);
        end
      end else begin
        check("q1q3_strobes", all_strobes, 0);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; en = 1'b0; instr_in = 14'h0; alu_z = 1'b0; alu_bit_test_res = 1'b0;
    cur_ir = 14'h0; cur_flush = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_q_phase", q_phase, 0);
    check("reset_ir", ir, 0);
    check("reset_flushing", flushing, 0);
    check("reset_strobes", all_strobes, 0);
    check("reset_alu_op", alu_op, 0);
    check("reset_alu_sel_lit", alu_sel_lit, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    mon_on = 1'b1;

    run_cycle(14'h3E05, 0, 0, 0);
    run_cycle(14'h07A0, 0, 0, 0);
    run_cycle(14'h2923, 0, 0, 0);
    run_cycle(14'h3FFF, 0, 0, 0);
    run_cycle(14'h0BA1, 0, 0, 0);
    run_cycle(14'h0BA1, 1, 0, 0);
    run_cycle(14'h0BA1, 0, 0, 0);
    run_cycle(14'h1D03, 0, 0, 0);
    run_cycle(14'h2050, 0, 1, 0);
    run_cycle(14'h2050, 0, 0, 0);
    run_cycle(14'h0008, 0, 0, 0);
    run_cycle(14'h0008, 0, 0, 0);
    run_cycle(14'h0000, 0, 0, 0);
    run_cycle(14'h0000, 0, 0, 0);

    for (int k = 0; k < 300; k++) begin
      run_cycle(rand_instr(), 1'($urandom), 1'($urandom), 25);
    end
    run_cycle(14'h07A0, 0, 0, 0);
    run_cycle(14'h07A0, 0, 0, 0);

    check("q2_drained", q2_q.size(), 0);
    check("q4_drained", q4_q.size(), 0);

    mon_on = 1'b0;
    en = 1'b1;
    @(posedge clk); #1;
    en = 1'b0;
    for (int s = 0; s < 3; s++) begin
      @(posedge clk); #1;
      check("hold_q_phase", q_phase, 1);
      check("hold_strobes", all_strobes, 0);
    end
    en = 1'b1;
    @(posedge clk); #1;
    check("resume_q_phase", q_phase, 2);
    rst = 1'b1;
    @(posedge clk); #1;
    check("midrst_q_phase", q_phase, 0);
    check("midrst_ir", ir, 0);
    check("midrst_flushing", flushing, 0);
    check("midrst_strobes", all_strobes, 0);
    check("midrst_alu_op", alu_op, 0);
    check("midrst_literal", literal, 0);
    check("midrst_pc_load_addr", pc_load_addr, 0);
    rst = 1'b0;
    en = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/instr_sequencer.md
Name: instr_sequencer

Overview:
Q-cycle controller for the PIC16F-compatible core. It holds the instruction register and divides each instruction cycle into four clocks (Q1–Q4). It decodes the 14-bit mid-range opcode into ALU op, operand select, register-file/W write enables and PC/stack control. It sequences the existing ALU and register file, and inserts a flush cycle after branches and taken skips.

Parameters:
PC_WIDTH, 13, width of program counter / branch target bus
RF_ADDR_WIDTH, 7, register file direct-address width (bank bits handled by the regfile)

Ports:
clk  in  1  system clock
rst  in  1  reset, synchronous, active-high
en  in  1  advance enable; low freezes Q counter and suppresses all enables
instr_in  in  14  program memory data at current PC; sampled at Q4
alu_z  in  1  ALU zero result (alu_out==0), valid Q3–Q4
alu_bit_test_res  in  1  value of tested bit (1 = set), valid Q3–Q4
q_phase  out  2  0..3 = Q1..Q4
ir  out  14  current instruction register
alu_op  out  4  ALU operation code (shared ALU op constants)
alu_sel_lit  out  1  1 = ALU op_lf is literal ir[7:0]; 0 = regfile read data
literal  out  8  ir[7:0]
alu_status_wr_en  out  1  ALU status write qualifier; Q4 only
rf_addr  out  RF_ADDR_WIDTH  ir[6:0]
rf_rd_en  out  1  register read strobe; Q2
rf_wr_en  out  1  register writeback; Q4
w_wr_en  out  1  W writeback; Q4
bit_sel  out  3  ir[9:7] for BCF/BSF/BTFSx
bit_set_en  out  1  BSF writeback mode (Q4)
bit_clr_en  out  1  BCF writeback mode (Q4)
pc_inc  out  1  PC increment; Q4
pc_load  out  1  load PC from pc_load_addr (GOTO/CALL); Q4
pc_load_addr  out  11  ir[10:0]
stack_push  out  1  CALL; Q4
stack_pop  out  1  RETURN/RETLW/RETFIE; PC reloads from stack; Q4
gie_set  out  1  RETFIE; Q4
flushing  out  1  current cycle is a forced NOP

Behaviour:
- Reset: q_phase=0, ir=14'h0000 (NOP), flush flag=0, every output 0.
- Q counter: increments mod 4 each clk while en=1; holds when en=0. All strobes are gated by en.
- Q1: decode only; no strobes. Q2: rf_rd_en=1 when the instruction reads f. Q3: ALU evaluates; no strobes.
- Q4: writebacks, PC/stack strobes, pc_inc=1, ir<=instr_in, and flush flag update.
- d-bit (ir[7]) on byte ops: 1 → rf_wr_en; 0 → w_wr_en.
- Literal ops write W. MOVWF and CLRF write f. CLRW writes W.
- Op mapping (ALU op): ADDWF/ADDLW→add; ANDWF/ANDLW→and; CLRF/CLRW→clr; COMF→com; DECF/DECFSZ→dec; INCF/INCFSZ→inc; IORWF/IORLW→or; MOVF→passlf; MOVWF→passw; RLF→rlf; RRF→rrf; SUBWF/SUBLW→sub; SWAPF→swapf; XORWF/XORLW→xor; MOVLW/RETLW→passlf with alu_sel_lit=1.
- BCF/BSF/BTFSx use passlf on f.
- alu_status_wr_en=1 at Q4 except for: DECFSZ, INCFSZ, MOVWF, SWAPF, MOVLW, RETLW, bit ops, branches, NOP, SLEEP, CLRWDT. SLEEP and CLRWDT decode as NOP.
- Skips, evaluated at Q4:
  - DECFSZ/INCFSZ skip when alu_z=1.
  - BTFSC skips when alu_bit_test_res=0.
  - BTFSS skips when alu_bit_test_res=1.
- Flush flag is set at Q4 on: a taken skip, GOTO, CALL, RETURN, RETLW, RETFIE. Otherwise it is cleared at Q4.
- While the flush flag is set: flushing=1 and the IR is treated as NOP (no rf/w/status/stack/pc_load strobes). pc_inc and the IR load still occur.
- GOTO/CALL: pc_load=1 and pc_inc=0 in the same Q4; pc_load wins.
- RETURN/RETLW/RETFIE: stack_pop=1, pc_inc=0. RETLW also sets w_wr_en.
- Undefined encodings execute as NOP.
- rst asserted mid-cycle: immediate return to the reset state on the next clk; no partial Q4 strobes.
- en deasserted at Q4: no strobes fire; Q4 repeats when en returns.

Decomposition:
- Existing shared ALU op constants header: supplies alu_op codes.
- New shared header holds opcode match constants/masks, Q-phase constants (Q1..Q4) and instruction-class enum.
- One combinational sub-module, instr_decoder (ir → alu_op, class, writeback target, status_en, skip type). The sequencer keeps the Q counter, IR, flush flag and Q-phase gating.

Test Plan:
- Reset, then en=1, instr_in=14'h3E05 (ADDLW 0x05) → at the second cycle's Q4: alu_op=add, alu_sel_lit=1, w_wr_en=1, alu_status_wr_en=1, rf_wr_en=0.
- ADDWF 0x20,1 (14'h07A0) → Q2 rf_rd_en=1 with rf_addr=7'h20; Q4 rf_wr_en=1, w_wr_en=0, pc_inc=1.
- GOTO 0x123 (14'h2923) → Q4 pc_load=1, pc_load_addr=11'h123, pc_inc=0; next cycle flushing=1 with no writes.
- DECFSZ 0x21,1 (14'h0BA1): alu_z=1 → next cycle flushed; alu_z=0 → next cycle executes normally; alu_status_wr_en=0 in both cases.
- BTFSS 0x03,2 (14'h1D03) with alu_bit_test_res=1 → bit_sel=2, skip taken. CALL 0x050 (14'h2050) → stack_push=1. RETURN (14'h0008) → stack_pop=1, followed by a flush.
- en toggled low during Q2 for 3 clocks → q_phase holds at 1, no strobes; rst at Q3 → next clk all outputs 0, ir=0, q_phase=0.
